// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared dump states, fixed word roles and width helpers for data_memory_stream
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} dump_state_e;
  localparam int LEN_WORD = 0;
  localparam int FIRST_PAYLOAD = 1;
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: dump FSM that streams a length-prefixed memory block over valid/ready
module mem_dump_ctrl import data_mem_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable_i,
  input  logic                     ready_i,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  output logic [$clog2(DEPTH)-1:0] rd_idx_o,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     valid_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int LW = $clog2(DEPTH);
  dump_state_e state_q, state_d;
  logic en_q;
  logic [LW-1:0] len_q, len_d, ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic rise;
  assign rise = enable_i && !en_q;
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      len_q <= '0;
      ptr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q <= enable_i;
      len_q <= len_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  // The single dump read port fetches the length word while idle, so LOAD only needs the first payload word.
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    ptr_d = ptr_q;
    data_d = data_q;
    valid_d = valid_q;
    rd_idx_o = LW'(LEN_WORD);
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = LOAD;
          len_d = (rd_data_i > DATA_WIDTH'(DEPTH - 1)) ? LW'(DEPTH - 1) : rd_data_i[LW-1:0];
          ptr_d = LW'(FIRST_PAYLOAD);
        end
      end
      LOAD: begin
        rd_idx_o = LW'(FIRST_PAYLOAD);
        if (!enable_i) state_d = IDLE;
        else if (len_q == '0) state_d = DONE;
        else begin
          state_d = SEND;
          data_d = rd_data_i;
          valid_d = 1'b1;
        end
      end
      SEND: begin
        rd_idx_o = ptr_q + LW'(1);
        if (!enable_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (ready_i) begin
          if (ptr_q == len_q) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            ptr_d = ptr_q + LW'(1);
            data_d = rd_data_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/data_memory_stream.sv
// data_memory_stream: word-addressed data RAM with byte-enable CPU port and UART dump engine
module data_memory_stream import data_mem_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            writeEn,
  input  logic                            readEn,
  input  logic [be_width(DATA_WIDTH)-1:0] byteEn,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           dataIn,
  output logic [DATA_WIDTH-1:0]           dataOut,
  output logic                            addrError,
  input  logic                            enableUart,
  output logic [DATA_WIDTH-1:0]           dataUart,
  output logic                            uartValid,
  input  logic                            uartReady,
  output logic                            uartBusy,
  output logic                            uartDone
);
  localparam int LW = $clog2(DEPTH);
  localparam int NB = be_width(DATA_WIDTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic addr_err_q;
  logic in_range;
  logic [LW-1:0] idx, dump_idx;
  logic [DATA_WIDTH-1:0] dump_data;
  assign in_range = address < ADDR_WIDTH'(DEPTH);
  assign idx = address[LW-1:0];
  assign dump_data = mem_q[dump_idx];
  assign dataOut = data_out_q;
  assign addrError = addr_err_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_out_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      if (writeEn && in_range)
        for (int b = 0; b < NB; b++)
          if (byteEn[b]) mem_q[idx][8*b +: 8] <= dataIn[8*b +: 8];
      if (readEn) data_out_q <= in_range ? mem_q[idx] : '0;
      addr_err_q <= (readEn || writeEn) && !in_range;
    end
  end
  mem_dump_ctrl #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_dump (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (enableUart),
    .ready_i   (uartReady),
    .rd_data_i (dump_data),
    .rd_idx_o  (dump_idx),
    .data_o    (dataUart),
    .valid_o   (uartValid),
    .busy_o    (uartBusy),
    .done_o    (uartDone)
  );
endmodule

// File: tb/tb_data_memory_stream.sv
// tb_data_memory_stream: directed scoreboard bench for the data RAM CPU port and dump engine
module tb_data_memory_stream;
  logic clk = 1'b0;
  logic rst, writeEn, readEn, enableUart, uartReady;
  logic [3:0] byteEn;
  logic [31:0] address, dataIn;
  logic [31:0] dataOut, dataUart;
  logic addrError, uartValid, uartBusy, uartDone;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  data_memory_stream #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .writeEn(writeEn), .readEn(readEn), .byteEn(byteEn),
    .address(address), .dataIn(dataIn), .dataOut(dataOut), .addrError(addrError),
    .enableUart(enableUart), .dataUart(dataUart), .uartValid(uartValid),
    .uartReady(uartReady), .uartBusy(uartBusy), .uartDone(uartDone)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    writeEn = 1'b1; address = a; dataIn = d; byteEn = be;
    tick();
    writeEn = 1'b0; byteEn = 4'h0;
  endtask
  task automatic rd(input logic [31:0] a);
    readEn = 1'b1; address = a;
    tick();
    readEn = 1'b0;
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dataOut"}, dataOut, 32'h0);
    chk({tag, "_addrError"}, 32'(addrError), 32'h0);
    chk({tag, "_dataUart"}, dataUart, 32'h0);
    chk({tag, "_uartValid"}, 32'(uartValid), 32'h0);
    chk({tag, "_uartBusy"}, 32'(uartBusy), 32'h0);
    chk({tag, "_uartDone"}, 32'(uartDone), 32'h0);
  endtask
  task automatic run_dump(input string tag, input int exp_cycles);
    int cycles = 0;
    bit done = 1'b0;
    while (!done && cycles < 200) begin
      if (uartDone) done = 1'b1;
      else begin
        if (uartValid && uartReady) begin
          if (exp_q.size() == 0) chk({tag, "_extra_word"}, 32'(uartValid), 32'h0);
          else chk({tag, "_word"}, dataUart, exp_q.pop_front());
        end
        tick();
        cycles++;
      end
    end
    chk({tag, "_done_seen"}, 32'(done), 32'h1);
    chk({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
    chk({tag, "_words_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    tick();
    chk({tag, "_busy_after"}, 32'(uartBusy), 32'h0);
    chk({tag, "_done_after"}, 32'(uartDone), 32'h0);
    enableUart = 1'b0;
    tick();
  endtask
  initial begin
    rst = 1'b0; writeEn = 1'b0; readEn = 1'b0; enableUart = 1'b0; uartReady = 1'b0;
    byteEn = 4'h0; address = '0; dataIn = '0;
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b1;
    wr(2, 32'hAAF00FAA, 4'hF);
    wr(2, 32'h12345678, 4'b0101);
    rd(2);
    chk("byte_en_read", dataOut, 32'hAA340F78);
    tick();
    chk("read_hold", dataOut, 32'hAA340F78);
    wr(1, 32'h11111111, 4'hF);
    writeEn = 1'b1; readEn = 1'b1; address = 1; dataIn = 32'h22222222; byteEn = 4'hF;
    tick();
    writeEn = 1'b0; readEn = 1'b0;
    chk("read_first", dataOut, 32'h11111111);
    rd(1);
    chk("read_after_write", dataOut, 32'h22222222);
    rd(64);
    chk("oor_read_data", dataOut, 32'h0);
    chk("oor_read_err", 32'(addrError), 32'h1);
    tick();
    chk("oor_err_clear", 32'(addrError), 32'h0);
    wr(64, 32'hFFFFFFFF, 4'hF);
    chk("oor_write_err", 32'(addrError), 32'h1);
    rd(0);
    chk("oor_write_ignored", dataOut, 32'h0);
    chk("in_range_err", 32'(addrError), 32'h0);
    wr(0, 32'd2, 4'hF);
    wr(1, 32'hAEF039A8, 4'hF);
    wr(2, 32'hAAF00FAA, 4'hF);
    uartReady = 1'b1;
    exp_q.push_back(32'hAEF039A8);
    exp_q.push_back(32'hAAF00FAA);
    enableUart = 1'b1;
    tick();
    chk("basic_load_busy", 32'(uartBusy), 32'h1);
    chk("basic_load_valid", 32'(uartValid), 32'h0);
    run_dump("basic", 3);
    uartReady = 1'b0;
    enableUart = 1'b1;
    tick();
    tick();
    chk("bp_valid0", 32'(uartValid), 32'h1);
    chk("bp_data0", dataUart, 32'hAEF039A8);
    wr(1, 32'h0, 4'hF);
    chk("bp_snap_valid", 32'(uartValid), 32'h1);
    chk("bp_snap_data", dataUart, 32'hAEF039A8);
    wr(2, 32'h5, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", 32'(uartValid), 32'h1);
      chk("bp_hold_data", dataUart, 32'hAEF039A8);
    end
    exp_q.push_back(32'hAEF039A8);
    exp_q.push_back(32'h5);
    uartReady = 1'b1;
    run_dump("backpressure", 2);
    wr(0, 32'd0, 4'hF);
    enableUart = 1'b1;
    tick();
    run_dump("len_zero", 1);
    for (int i = 1; i < 64; i++) begin
      wr(i, 32'hC0DE0000 | i, 4'hF);
      exp_q.push_back(32'hC0DE0000 | i);
    end
    wr(0, 32'd200, 4'hF);
    enableUart = 1'b1;
    tick();
    run_dump("len_clamp", 64);
    wr(0, 32'd3, 4'hF);
    enableUart = 1'b1;
    tick();
    tick();
    chk("abort_first_word", dataUart, 32'hC0DE0001);
    tick();
    chk("abort_second_word", dataUart, 32'hC0DE0002);
    enableUart = 1'b0;
    tick();
    chk("abort_valid", 32'(uartValid), 32'h0);
    chk("abort_busy", 32'(uartBusy), 32'h0);
    chk("abort_done", 32'(uartDone), 32'h0);
    tick();
    chk("abort_done_later", 32'(uartDone), 32'h0);
    uartReady = 1'b0;
    enableUart = 1'b1;
    tick();
    tick();
    chk("restart_valid", 32'(uartValid), 32'h1);
    chk("restart_word", dataUart, 32'hC0DE0001);
    rst = 1'b0;
    tick();
    chk_idle_outputs("mid_reset");
    rst = 1'b1; enableUart = 1'b0;
    tick();
    chk("mid_reset_no_done", 32'(uartDone), 32'h0);
    rd(1);
    chk("mid_reset_mem1", dataOut, 32'h0);
    rd(63);
    chk("mid_reset_mem63", dataOut, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
